// File: rtl/delay_pipe.sv
// Purpose: DEPTH-stage shift pipeline carrying {data, valid}, with an occupancy count of valid stages.
// Latency: DEPTH enabled edges from D_i/vld_i to Q_o/vld_o; edges with en_i low add no progress.
// Backpressure: none; en_i low freezes every stage and fill_o, and clr_i empties the pipe (clear beats shift).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (data stages -> RESET_VAL, valids/fill -> 0)
//   en_i       shift enable
//   clr_i      synchronous clear
//   D_i,vld_i  sample entering stage 0
//   Q_o,vld_o  sample leaving stage DEPTH-1 (registered)
//   fill_o     number of stages currently holding a valid flag
// Optional (macro DELAY_PIPE_TAP_EN):
//   tap_sel_i  stage index to observe
//   tap_o,tap_vld_o  combinational view of the selected stage; RESET_VAL/0 when the index is out of range
module delay_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              FW        = $clog2(DEPTH + 1),
  localparam int              TSW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] D_i,
  input  logic             vld_i,
`ifdef DELAY_PIPE_TAP_EN
  input  logic [TSW-1:0]   tap_sel_i,
  output logic [WIDTH-1:0] tap_o,
  output logic             tap_vld_o,
`endif
  output logic [WIDTH-1:0] Q_o,
  output logic             vld_o,
  output logic [FW-1:0]    fill_o
);

  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [FW-1:0]    fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= RESET_VAL;
      vld_q  <= '0;
      fill_q <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= RESET_VAL;
      vld_q  <= '0;
      fill_q <= '0;
    end else if (en_i) begin
      // Data moves regardless of valid; invalid stages just carry stale bytes.
      dat_q[0] <= D_i;
      vld_q[0] <= vld_i;
      for (int k = 1; k < DEPTH; k++) begin
        dat_q[k] <= dat_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
      // One flag enters and one leaves per shift, so the count stays within 0..DEPTH.
      fill_q <= fill_q + FW'(vld_i) - FW'(vld_q[DEPTH-1]);
    end
  end

  assign Q_o    = dat_q[DEPTH-1];
  assign vld_o  = vld_q[DEPTH-1];
  assign fill_o = fill_q;

`ifdef DELAY_PIPE_TAP_EN
  // Compare-and-select mux so indices beyond DEPTH-1 fall through to the default.
  always_comb begin
    tap_o     = RESET_VAL;
    tap_vld_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel_i == TSW'(k)) begin
        tap_o     = dat_q[k];
        tap_vld_o = vld_q[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_delay_pipe.sv
module tb_delay_pipe;

  localparam logic [7:0] RV4 = 8'hE7;
  localparam logic [7:0] RV1 = 8'h3D;
  localparam logic [7:0] RV3 = 8'hC3;

  logic       clk;
  logic       reset;
  logic       en_i;
  logic       clr_i;
  logic [7:0] D_i;
  logic       vld_i;

  logic [7:0] q4;
  logic       v4;
  logic [2:0] f4;
  logic [7:0] q1;
  logic       v1;
  logic [0:0] f1;

  int checks = 0;
  int errors = 0;

  // Reference model: each pipe is a list of {data, valid}, newest at the front.
  logic [7:0] m4d[$];
  bit         m4v[$];
  logic [7:0] m1d[$];
  bit         m1v[$];

`ifdef DELAY_PIPE_TAP_EN
  logic [1:0] tap_sel4;
  logic [7:0] tap4;
  logic       tapv4;
  logic [0:0] tap_sel1;
  logic [7:0] tap1;
  logic       tapv1;
  logic [1:0] tap_sel3;
  logic [7:0] tap3;
  logic       tapv3;
  logic [7:0] q3;
  logic       v3;
  logic [1:0] f3;

  delay_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
    .clk(clk), .reset(reset), .en_i(en_i), .clr_i(clr_i), .D_i(D_i), .vld_i(vld_i),
    .tap_sel_i(tap_sel4), .tap_o(tap4), .tap_vld_o(tapv4),
    .Q_o(q4), .vld_o(v4), .fill_o(f4));
  delay_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .reset(reset), .en_i(en_i), .clr_i(clr_i), .D_i(D_i), .vld_i(vld_i),
    .tap_sel_i(tap_sel1), .tap_o(tap1), .tap_vld_o(tapv1),
    .Q_o(q1), .vld_o(v1), .fill_o(f1));
  delay_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV3)) dut3 (
    .clk(clk), .reset(reset), .en_i(en_i), .clr_i(clr_i), .D_i(D_i), .vld_i(vld_i),
    .tap_sel_i(tap_sel3), .tap_o(tap3), .tap_vld_o(tapv3),
    .Q_o(q3), .vld_o(v3), .fill_o(f3));
`else
  delay_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
    .clk(clk), .reset(reset), .en_i(en_i), .clr_i(clr_i), .D_i(D_i), .vld_i(vld_i),
    .Q_o(q4), .vld_o(v4), .fill_o(f4));
  delay_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .reset(reset), .en_i(en_i), .clr_i(clr_i), .D_i(D_i), .vld_i(vld_i),
    .Q_o(q1), .vld_o(v1), .fill_o(f1));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    m4d.delete(); m4v.delete(); m1d.delete(); m1v.delete();
    for (int k = 0; k < 4; k++) begin
      m4d.push_back(RV4);
      m4v.push_back(1'b0);
    end
    m1d.push_back(RV1);
    m1v.push_back(1'b0);
  endtask

  task automatic model_edge();
    if (clr_i) begin
      model_clear();
    end else if (en_i) begin
      m4d.push_front(D_i); m4v.push_front(vld_i);
      void'(m4d.pop_back()); void'(m4v.pop_back());
      m1d.push_front(D_i); m1v.push_front(vld_i);
      void'(m1d.pop_back()); void'(m1v.pop_back());
    end
  endtask

  function automatic logic [2:0] pop4();
    int n = 0;
    foreach (m4v[k]) n += int'(m4v[k]);
    return 3'(n);
  endfunction

  // Inputs change on the falling edge; the model follows each rising edge; outputs are read at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en_i = 1'b1; clr_i = 1'b0; D_i = 8'h99; vld_i = 1'b1;
`ifdef DELAY_PIPE_TAP_EN
    tap_sel4 = 2'd0; tap_sel1 = 1'b0; tap_sel3 = 2'd3;
`endif
    model_clear();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({q4, v4, f4} !== {RV4, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset4: got q=%h v=%b f=%0d want q=%h v=0 f=0", q4, v4, f4, RV4);
    end
    checks++;
    if ({q1, v1, f1} !== {RV1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset1: got q=%h v=%b f=%0d want q=%h v=0 f=0", q1, v1, f1, RV1);
    end
    reset = 1'b1; en_i = 1'b0; vld_i = 1'b0;
  endtask

  task automatic test_latency();
    do_clear();
    en_i = 1'b1; D_i = 8'hA5; vld_i = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      D_i = 8'h00; vld_i = 1'b0;
      checks++;
      if ({v4, f4} !== {1'(n == 4), 3'(n <= 4)}) begin
        errors++;
        $display("FAIL latency edge %0d: got v=%b f=%0d want v=%b f=%0d", n, v4, f4, n == 4, n <= 4);
      end
      if (n == 4) begin
        checks++;
        if (q4 !== 8'hA5) begin
          errors++;
          $display("FAIL latency data: got %h want a5", q4);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_clear();
    en_i = 1'b1; D_i = 8'hA5; vld_i = 1'b1;
    tick();
    D_i = 8'h00; vld_i = 1'b0;
    tick();
    // Junk on the inputs while stalled must not enter the pipe.
    en_i = 1'b0; D_i = 8'h5F; vld_i = 1'b1;
    for (int n = 3; n <= 5; n++) begin
      tick();
      checks++;
      if ({v4, f4} !== {1'b0, 3'd1}) begin
        errors++;
        $display("FAIL stall edge %0d: got v=%b f=%0d want v=0 f=1", n, v4, f4);
      end
    end
    en_i = 1'b1; vld_i = 1'b0; D_i = 8'h00;
    tick();
    checks++;
    if ({v4, f4} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL stall edge 6: got v=%b f=%0d want v=0 f=1", v4, f4);
    end
    tick();
    checks++;
    if ({q4, v4, f4} !== {8'hA5, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL stall edge 7: got q=%h v=%b f=%0d want q=a5 v=1 f=1", q4, v4, f4);
    end
  endtask

  task automatic test_clear();
    for (int pass = 0; pass < 2; pass++) begin
      do_clear();
      en_i = 1'b1; vld_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
        D_i = 8'($urandom);
        tick();
      end
      checks++;
      if ({v4, f4} !== {1'b1, 3'd4}) begin
        errors++;
        $display("FAIL clear prefill: got v=%b f=%0d want v=1 f=4", v4, f4);
      end
      clr_i = 1'b1; en_i = (pass == 0);
      tick();
      clr_i = 1'b0;
      checks++;
      if ({q4, v4, f4} !== {RV4, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL clear en=%0d: got q=%h v=%b f=%0d want q=%h v=0 f=0", pass == 0, q4, v4, f4, RV4);
      end
    end
    en_i = 1'b0; vld_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    en_i = 1'b1; vld_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      D_i = 8'($urandom);
      tick();
    end
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({q4, v4, f4} !== {RV4, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL async reset4: got q=%h v=%b f=%0d want q=%h v=0 f=0", q4, v4, f4, RV4);
    end
    checks++;
    if ({q1, v1, f1} !== {RV1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async reset1: got q=%h v=%b f=%0d want q=%h v=0 f=0", q1, v1, f1, RV1);
    end
    @(negedge clk);
    reset = 1'b1;
    D_i = 8'h3C; vld_i = 1'b1; en_i = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      D_i = 8'h00; vld_i = 1'b0;
      checks++;
      if (v4 !== 1'(n == 4)) begin
        errors++;
        $display("FAIL post-reset edge %0d: got v=%b want %b", n, v4, n == 4);
      end
    end
    checks++;
    if (q4 !== 8'h3C) begin
      errors++;
      $display("FAIL post-reset data: got %h want 3c", q4);
    end
  endtask

  task automatic test_depth1();
    do_clear();
    en_i = 1'b1; D_i = 8'h11; vld_i = 1'b1;
    tick();
    checks++;
    if ({q1, v1, f1} !== {8'h11, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL depth1 load: got q=%h v=%b f=%0d want q=11 v=1 f=1", q1, v1, f1);
    end
    en_i = 1'b0; D_i = 8'h22; vld_i = 1'b0;
    tick();
    checks++;
    if ({q1, v1, f1} !== {8'h11, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL depth1 hold: got q=%h v=%b f=%0d want q=11 v=1 f=1", q1, v1, f1);
    end
    do_clear();
    checks++;
    if ({q1, v1, f1} !== {RV1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL depth1 clear: got q=%h v=%b f=%0d want q=%h v=0 f=0", q1, v1, f1, RV1);
    end
  endtask

`ifdef DELAY_PIPE_TAP_EN
  task automatic test_tap();
    do_clear();
    en_i = 1'b1; vld_i = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      D_i = 8'(n);
      tick();
    end
    en_i = 1'b0; vld_i = 1'b0;
    tap_sel4 = 2'd0; tap_sel1 = 1'b0; tap_sel3 = 2'd3;
    #1;
    checks++;
    if ({tap4, tapv4} !== {8'h04, 1'b1}) begin
      errors++;
      $display("FAIL tap sel0: got %h/%b want 04/1", tap4, tapv4);
    end
    checks++;
    if ({tap1, tapv1} !== {8'h04, 1'b1}) begin
      errors++;
      $display("FAIL tap depth1: got %h/%b want 04/1", tap1, tapv1);
    end
    checks++;
    if ({tap3, tapv3} !== {RV3, 1'b0}) begin
      errors++;
      $display("FAIL tap out-of-range: got %h/%b want %h/0", tap3, tapv3, RV3);
    end
    tap_sel4 = 2'd3;
    #1;
    checks++;
    if ({tap4, tapv4} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL tap sel3: got %h/%b want 01/1", tap4, tapv4);
    end
  endtask
`endif

  task automatic test_random();
    logic [11:0] exp4;
    logic [9:0]  exp1;
    do_clear();
    for (int c = 0; c < 400; c++) begin
      en_i  = ($urandom_range(0, 3) != 0);
      clr_i = ($urandom_range(0, 24) == 0);
      D_i   = 8'($urandom);
      vld_i = 1'($urandom_range(0, 1));
      tick();
      exp4 = {m4d[3], 1'(m4v[3]), pop4()};
      exp1 = {m1d[0], 1'(m1v[0]), 1'(m1v[0])};
      checks++;
      if ({q4, v4, f4} !== exp4) begin
        errors++;
        $display("FAIL random4 cycle %0d: got q=%h v=%b f=%0d want q=%h v=%b f=%0d",
                 c, q4, v4, f4, exp4[11:4], exp4[3], exp4[2:0]);
      end
      checks++;
      if ({q1, v1, f1} !== exp1) begin
        errors++;
        $display("FAIL random1 cycle %0d: got q=%h v=%b f=%0d want q=%h v=%b f=%0d",
                 c, q1, v1, f1, exp1[9:2], exp1[1], exp1[0]);
      end
    end
    clr_i = 1'b0; en_i = 1'b0; vld_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_clear();
    test_async_reset();
    test_depth1();
`ifdef DELAY_PIPE_TAP_EN
    test_tap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
